// File: rtl/shift_sequencer_pkg.sv
// rtl/shift_sequencer_pkg.sv - shift direction, sequencer state types and width defaults
package shift_sequencer_pkg;

  localparam int W_DEF     = 7;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [1:0] {
    No_Shift    = 2'd0,
    Shift_Right = 2'd1,
    Shift_Left  = 2'd2
  } SH_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ShSeq_t;

endpackage

// File: rtl/shift_sequencer_step.sv
// rtl/shift_sequencer_step.sv - combinational one-bit logical shifter slaved to an SH_t command
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] op,
  input  SH_t          sh,
  output logic [W-1:0] op_out
);

  // Unknown encodings pass the operand through untouched.
  always_comb begin
    op_out = op;
    case (sh)
      Shift_Right: op_out = {1'b0, op[W-1:1]};
      Shift_Left:  op_out = {op[W-2:0], 1'b0};
      default:     op_out = op;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle shift unit issuing one SH_t step command per clock
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  SH_t              dir,
  input  logic [CNT_W-1:0] amount,
  input  logic [W-1:0]     A,
  output logic             busy,
  output logic             done,
  output SH_t              SLSR,
  output logic [W-1:0]     A_out
);

  ShSeq_t           state_q, state_d;
  logic [W-1:0]     op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  SH_t              dir_q, dir_d;
  logic [W-1:0]     op_step;

  shift_step #(.W(W)) u_step (
    .op     (op_q),
    .sh     (dir_q),
    .op_out (op_step)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = A;
          cnt_d = amount;
          dir_d = dir;
          // Zero-length or non-shifting requests skip straight to the result.
          state_d = (amount == '0 || dir == No_Shift) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        op_d  = op_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= No_Shift;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign SLSR  = (state_q == SHIFT) ? dir_q : No_Shift;
  assign A_out = op_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - scoreboard bench for shift_sequencer
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  typedef struct {
    logic [6:0] a;
    int         lat;
    int         slsr;
    int         busy;
    SH_t        dir;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  SH_t        dir = No_Shift;
  logic [2:0] amount = '0;
  logic [6:0] A = '0;
  logic       busy, done;
  SH_t        SLSR;
  logic [6:0] A_out;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   acc_q[$];
  int   acc_count = 0;
  int   done_count = 0;
  int   last_acc_cyc = 0;
  int   last_done_cyc = 0;
  int   slsr_cnt = 0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  shift_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dir    (dir),
    .amount (amount),
    .A      (A),
    .busy   (busy),
    .done   (done),
    .SLSR   (SLSR),
    .A_out  (A_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic exp_t model(SH_t d, int n, logic [6:0] a);
    exp_t e;
    logic [6:0] v;
    bit degen;
    v = a;
    degen = (n == 0) || (d == No_Shift);
    for (int i = 0; i < n; i++) begin
      if (d == Shift_Right) v = v >> 1;
      else if (d == Shift_Left) v = v << 1;
    end
    e.a    = v;
    e.lat  = degen ? 1 : n + 1;
    e.slsr = degen ? 0 : n;
    e.busy = degen ? 1 : n + 1;
    e.dir  = d;
    return e;
  endfunction

  // Monitor: acceptance shows up as a rising busy, results as the done pulse.
  always @(negedge clk) begin
    if (reset) begin
      slsr_cnt = 0;
      busy_cnt = 0;
    end else begin
      if (busy && !prev_busy) begin
        acc_q.push_back(cyc);
        acc_count++;
        last_acc_cyc = cyc;
      end
      if (!busy) busy_cnt = 0;
      else busy_cnt++;
      if (SLSR != No_Shift) begin
        slsr_cnt++;
        if (sb.size() > 0) check("slsr_dir", 32'(SLSR), 32'(sb[0].dir));
      end
      if (done) begin
        exp_t e;
        int acc;
        done_count++;
        last_done_cyc = cyc;
        check("done_expected", int'(sb.size() != 0 && acc_q.size() != 0), 1);
        if (sb.size() != 0 && acc_q.size() != 0) begin
          e = sb.pop_front();
          acc = acc_q.pop_front();
          check("a_out", 32'(A_out), 32'(e.a));
          check("latency", cyc - acc + 1, e.lat);
          check("slsr_cycles", slsr_cnt, e.slsr);
          check("busy_cycles", busy_cnt, e.busy);
        end
        slsr_cnt = 0;
      end
    end
    prev_busy = busy;
  end

  task automatic issue(input SH_t d, input int n, input logic [6:0] a, input bit keep);
    int base;
    bit got;
    @(negedge clk);
    dir = d;
    amount = 3'(n);
    A = a;
    start = 1'b1;
    sb.push_back(model(d, n, a));
    base = acc_count;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      if (acc_count > base) got = 1'b1;
    end
    check("accept", int'(got), 1);
    if (!keep) start = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !busy) idle = 1'b1;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int base_acc;
    int base_done;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_a_out", 32'(A_out), 0);
    check("rst_slsr", 32'(SLSR), 32'(No_Shift));
    reset = 1'b0;

    issue(Shift_Right, 3, 7'h55, 1'b0); wait_idle();
    issue(Shift_Left, 2, 7'h55, 1'b0);  wait_idle();
    issue(Shift_Right, 7, 7'h7F, 1'b0); wait_idle();
    issue(Shift_Left, 7, 7'h41, 1'b0);  wait_idle();
    issue(Shift_Left, 1, 7'h41, 1'b0);  wait_idle();
    issue(Shift_Left, 0, 7'h33, 1'b0);  wait_idle();
    issue(No_Shift, 5, 7'h33, 1'b0);    wait_idle();

    // A start pulse mid-SHIFT must be ignored entirely.
    issue(Shift_Right, 5, 7'h55, 1'b0);
    base_acc = acc_count;
    @(negedge clk);
    A = 7'h01; dir = Shift_Left; amount = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("ignored_start", acc_count, base_acc);

    // Start held high: the second request lands one idle cycle after done.
    issue(Shift_Left, 3, 7'h0F, 1'b1);
    issue(Shift_Right, 2, 7'h70, 1'b1);
    check("b2b_gap", last_acc_cyc - last_done_cyc, 2);
    start = 1'b0;
    wait_idle();

    // Reset after two of five steps discards the operation.
    issue(Shift_Left, 5, 7'h41, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    base_done = done_count;
    @(negedge clk);
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_a_out", 32'(A_out), 0);
    check("mid_rst_slsr", 32'(SLSR), 32'(No_Shift));
    sb.delete();
    acc_q.delete();
    reset = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("no_done_after_rst", done_count, base_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
